// File: rtl/execute_unit.sv
// execute_unit: execute stage of the 16-bit datapath.
// One ALU op per clock for ADD/SUB/AND/OR/XOR/SHL/SHR. The result goes to the
// register-file write port one cycle after the op is accepted, together with
// {C,N,Z} status flags.
// Optional feature macro: EXEC_MUL_EN builds the iterative shift-add
// multiplier (op 7). While the multiplier runs, i_in_valid/o_in_ready stall
// further issues. Without the macro, op 7 raises a one-cycle o_illegal_op.
module execute_unit #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_in_op,
    input  logic [WIDTH-1:0] i_in_a,
    input  logic [WIDTH-1:0] i_in_b,
    input  logic [3:0]       i_in_dest,
    output logic             o_reg_write_en,
    output logic [3:0]       o_reg_write_dest,
    output logic [WIDTH-1:0] o_reg_write_data,
    output logic [2:0]       o_flags,
    output logic             o_illegal_op
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    // Single-cycle ALU. Returns {carry, result}. Shifts use only b[3:0]. The
    // carry is the last bit pushed out, and it is zero for a zero shift.
    function automatic logic [WIDTH:0] alu_f(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]     sum;
        logic [2*WIDTH-1:0] sh;
        logic [3:0]         amt;
        logic               c;
        logic [WIDTH-1:0]   res;
        amt = b[3:0];
        sum = {(WIDTH+1){1'b0}};
        sh  = {(2*WIDTH){1'b0}};
        c   = 1'b0;
        res = {WIDTH{1'b0}};
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
            end
            OP_SUB: begin
                res = a - b;
                c   = (a < b);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SHL: begin
                sh  = {{WIDTH{1'b0}}, a} << amt;
                res = sh[WIDTH-1:0];
                c   = (amt != 4'd0) ? sh[WIDTH] : 1'b0;
            end
            OP_SHR: begin
                sh  = {a, {WIDTH{1'b0}}} >> amt;
                res = sh[2*WIDTH-1:WIDTH];
                c   = (amt != 4'd0) ? sh[WIDTH-1] : 1'b0;
            end
            default: begin
                res = {WIDTH{1'b0}};
                c   = 1'b0;
            end
        endcase
        return {c, res};
    endfunction

    // Builds the {C,N,Z} flag word from a carry and a result.
    function automatic logic [2:0] flags_f(
        input logic             c,
        input logic [WIDTH-1:0] res
    );
        return {c, res[WIDTH-1], (res == {WIDTH{1'b0}})};
    endfunction

    logic [WIDTH:0]   w_alu;
    logic             w_accept;
    logic             r_we;
    logic [3:0]       r_dest;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       r_flags;

    // Evaluate the ALU on the issued operands.
    always_comb begin
        w_alu = alu_f(i_in_op, i_in_a, i_in_b);
    end

    assign w_accept         = i_in_valid && o_in_ready;
    assign o_reg_write_en   = r_we;
    assign o_reg_write_dest = r_dest;
    assign o_reg_write_data = r_data;
    assign o_flags          = r_flags;

`ifdef EXEC_MUL_EN
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [3:0]         r_cnt;
    logic [3:0]         r_mdest;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_mul_last;

    assign o_in_ready   = (r_state == ST_IDLE);
    assign o_illegal_op = 1'b0;
    assign w_mul_last   = (r_cnt == 4'(MUL_CYCLES - 1));
    // Accumulator value after the current iteration.
    assign w_prod       = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: enter MUL on a multiply issue and leave after the last iteration.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (i_in_op == OP_MUL)) begin
                    w_state_nxt = ST_MUL;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (w_mul_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_MUL;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Multiplier datapath: latch the operands on issue, then do one shift-add step per clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mcand  <= {(2*WIDTH){1'b0}};
            r_acc    <= {(2*WIDTH){1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_cnt    <= 4'd0;
            r_mdest  <= 4'd0;
        end else if (w_accept && (i_in_op == OP_MUL)) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_in_a};
            r_acc    <= {(2*WIDTH){1'b0}};
            r_mplier <= i_in_b;
            r_cnt    <= 4'd0;
            r_mdest  <= i_in_dest;
        end else if (r_state == ST_MUL) begin
            r_acc    <= w_prod;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 4'd1;
        end
    end

    // Write port and flags. Single-cycle results follow the accept. Multiply
    // results follow the last iteration.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we    <= 1'b0;
            r_dest  <= 4'd0;
            r_data  <= {WIDTH{1'b0}};
            r_flags <= 3'd0;
        end else begin
            r_we <= 1'b0;
            if (w_accept && (i_in_op != OP_MUL)) begin
                r_we    <= 1'b1;
                r_dest  <= i_in_dest;
                r_data  <= w_alu[WIDTH-1:0];
                r_flags <= flags_f(w_alu[WIDTH], w_alu[WIDTH-1:0]);
            end else if ((r_state == ST_MUL) && w_mul_last) begin
                r_we    <= 1'b1;
                r_dest  <= r_mdest;
                r_data  <= w_prod[WIDTH-1:0];
                r_flags <= flags_f(|w_prod[2*WIDTH-1:WIDTH], w_prod[WIDTH-1:0]);
            end
        end
    end
`else
    logic r_ill;

    assign o_in_ready   = 1'b1;
    assign o_illegal_op = r_ill;

    // Write port and flags. Op 7 writes nothing and raises a one-cycle illegal pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we    <= 1'b0;
            r_dest  <= 4'd0;
            r_data  <= {WIDTH{1'b0}};
            r_flags <= 3'd0;
            r_ill   <= 1'b0;
        end else begin
            r_we  <= 1'b0;
            r_ill <= w_accept && (i_in_op == OP_MUL);
            if (w_accept && (i_in_op != OP_MUL)) begin
                r_we    <= 1'b1;
                r_dest  <= i_in_dest;
                r_data  <= w_alu[WIDTH-1:0];
                r_flags <= flags_f(w_alu[WIDTH], w_alu[WIDTH-1:0]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit. It follows the EXEC_MUL_EN macro the
// same way the design does.
module tb_execute_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_op = 3'd0;
    logic [15:0] in_a = 16'd0;
    logic [15:0] in_b = 16'd0;
    logic [3:0]  in_dest = 4'd0;
    logic        in_ready;
    logic        we;
    logic [3:0]  wdest;
    logic [15:0] wdata;
    logic [2:0]  flags;
    logic        ill;

    int checks = 0;
    int failures = 0;

    execute_unit dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_in_valid       (in_valid),
        .o_in_ready       (in_ready),
        .i_in_op          (in_op),
        .i_in_a           (in_a),
        .i_in_b           (in_b),
        .i_in_dest        (in_dest),
        .o_reg_write_en   (we),
        .o_reg_write_dest (wdest),
        .o_reg_write_data (wdata),
        .o_flags          (flags),
        .o_illegal_op     (ill)
    );

    always #5 clk = ~clk;

    // Reference model. Returns {C, N, Z, data[15:0]} from integer arithmetic.
    function automatic logic [18:0] ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int unsigned ua, ub, s, r;
        logic        c;
        logic [15:0] res;
        ua = a; ub = b; s = ub % 16; c = 1'b0; r = 0;
        case (op)
            3'd0: begin r = ua + ub; c = (r > 65535); end
            3'd1: begin r = (ua + 65536 - ub) % 65536; c = (ua < ub); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin r = (ua << s) % 65536; c = (s != 0) ? ((ua >> (16 - s)) % 2 == 1) : 1'b0; end
            3'd6: begin r = ua >> s; c = (s != 0) ? ((ua >> (s - 1)) % 2 == 1) : 1'b0; end
            default: begin r = ua * ub; c = ((r / 65536) != 0); end
        endcase
        res = r[15:0];
        return {c, res[15], (res == 16'd0), res};
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] d);
        in_valid = v; in_op = op; in_a = a; in_b = b; in_dest = d;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we: got %0b want 0", we); end
        checks++; if (wdest !== 4'd0) begin failures++; $display("FAIL reset_dest: got %h want 0", wdest); end
        checks++; if (wdata !== 16'd0) begin failures++; $display("FAIL reset_data: got %h want 0000", wdata); end
        checks++; if (flags !== 3'd0) begin failures++; $display("FAIL reset_flags: got %b want 000", flags); end
        checks++; if (ill !== 1'b0) begin failures++; $display("FAIL reset_ill: got %0b want 0", ill); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_add_sub();
        drive(1'b1, 3'd0, 16'hFFFF, 16'h0001, 4'd3);
        tick();
        checks++; if (we !== 1'b1) begin failures++; $display("FAIL add_we: got %0b want 1", we); end
        checks++; if (wdest !== 4'd3) begin failures++; $display("FAIL add_dest: got %h want 3", wdest); end
        checks++; if (wdata !== 16'h0000) begin failures++; $display("FAIL add_data: got %h want 0000", wdata); end
        checks++; if (flags !== 3'b101) begin failures++; $display("FAIL add_flags: got %b want 101", flags); end
        drive(1'b1, 3'd1, 16'h0001, 16'h0002, 4'd5);
        tick();
        checks++; if ({we, wdest, wdata} !== {1'b1, 4'd5, 16'hFFFF}) begin failures++; $display("FAIL sub_write: got %0b %h %h want 1 5 ffff", we, wdest, wdata); end
        checks++; if (flags !== 3'b110) begin failures++; $display("FAIL sub_flags: got %b want 110", flags); end
        drive(1'b0, 3'd0, 16'h1111, 16'h2222, 4'd9);
        tick();
        checks++; if ({we, wdest, wdata, flags} !== {1'b0, 4'd5, 16'hFFFF, 3'b110}) begin failures++; $display("FAIL idle_hold: got %0b %h %h %b want 0 5 ffff 110", we, wdest, wdata, flags); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 3'd4, 16'h1234, 16'h00FF, 4'd1);
        tick();
        checks++; if ({we, wdest, wdata, flags} !== {1'b1, 4'd1, 16'h12CB, 3'b000}) begin failures++; $display("FAIL b2b_xor: got %0b %h %h %b want 1 1 12cb 000", we, wdest, wdata, flags); end
        drive(1'b1, 3'd5, 16'h8001, 16'h0001, 4'd2);
        tick();
        checks++; if ({we, wdest, wdata, flags} !== {1'b1, 4'd2, 16'h0002, 3'b100}) begin failures++; $display("FAIL b2b_shl: got %0b %h %h %b want 1 2 0002 100", we, wdest, wdata, flags); end
        drive(1'b1, 3'd6, 16'h0003, 16'h0010, 4'd4);
        tick();
        checks++; if ({we, wdest, wdata, flags} !== {1'b1, 4'd4, 16'h0003, 3'b000}) begin failures++; $display("FAIL b2b_shr: got %0b %h %h %b want 1 4 0003 000", we, wdest, wdata, flags); end
        drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        tick();
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL b2b_end: got %0b want 0", we); end
    endtask

    task automatic test_random();
        logic        v;
        logic [2:0]  op;
        logic [15:0] a, b;
        logic [3:0]  d;
        logic [18:0] r;
        logic [3:0]  m_dest;
        logic [15:0] m_data;
        logic [2:0]  m_flags;
        logic        e_we, e_ill;
        do_reset();
        m_dest = 4'd0; m_data = 16'd0; m_flags = 3'd0;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 3) != 0);
`ifdef EXEC_MUL_EN
            op = 3'($urandom_range(0, 6));
`else
            op = 3'($urandom_range(0, 7));
`endif
            a = 16'($urandom);
            b = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 20));
            d = 4'($urandom);
            drive(v, op, a, b, d);
            tick();
            e_we = v && (op != 3'd7);
            e_ill = v && (op == 3'd7);
            if (e_we) begin
                r = ref_op(op, a, b);
                m_dest = d; m_data = r[15:0]; m_flags = r[18:16];
            end
            checks++;
            if ({in_ready, we, wdest, wdata, flags, ill} !== {1'b1, e_we, m_dest, m_data, m_flags, e_ill}) begin
                failures++;
                $display("FAIL rand[%0d] op=%0d a=%h b=%h: got rdy=%0b we=%0b d=%h data=%h f=%b ill=%0b want rdy=1 we=%0b d=%h data=%h f=%b ill=%0b",
                         i, op, a, b, in_ready, we, wdest, wdata, flags, ill, e_we, m_dest, m_data, m_flags, e_ill);
            end
        end
        drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 3'd1, 16'h0001, 16'h0002, 4'd6);
        tick();
        drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({we, wdest, wdata, flags} !== {1'b0, 4'd0, 16'd0, 3'd0}) begin failures++; $display("FAIL async_reset: got %0b %h %h %b want 0 0 0000 000", we, wdest, wdata, flags); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

`ifdef EXEC_MUL_EN
    task automatic mul_case(input logic [15:0] a, input logic [15:0] b, input logic [3:0] d);
        logic [18:0] e;
        int bad;
        e = ref_op(3'd7, a, b);
        drive(1'b1, 3'd7, a, b, d);
        tick();
        checks++; if ({in_ready, we} !== 2'b00) begin failures++; $display("FAIL mul_start: got rdy=%0b we=%0b want 0 0", in_ready, we); end
        drive(1'b1, 3'd0, 16'($urandom), 16'($urandom), ~d);
        bad = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k < 16 && (in_ready !== 1'b0 || we !== 1'b0)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL mul_busy a=%h b=%h: got %0d bad cycles want 0", a, b, bad); end
        checks++;
        if ({in_ready, we, wdest, wdata, flags} !== {1'b1, 1'b1, d, e[15:0], e[18:16]}) begin
            failures++;
            $display("FAIL mul_result a=%h b=%h: got rdy=%0b we=%0b d=%h data=%h f=%b want 1 1 %h %h %b",
                     a, b, in_ready, we, wdest, wdata, flags, d, e[15:0], e[18:16]);
        end
        drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        tick();
        checks++; if ({we, wdata} !== {1'b0, e[15:0]}) begin failures++; $display("FAIL mul_single: got we=%0b data=%h want 0 %h", we, wdata, e[15:0]); end
    endtask

    task automatic test_mul();
        int strobes;
        mul_case(16'h0123, 16'h0100, 4'd7);
        mul_case(16'h0003, 16'h0005, 4'd2);
        for (int i = 0; i < 4; i++) mul_case(16'($urandom), 16'($urandom), 4'($urandom));
        mul_case(16'h00FF, 16'h0101, 4'd8);
        // Reset in the middle of a multiply.
        drive(1'b1, 3'd7, 16'h00FF, 16'h00FF, 4'd11);
        tick();
        drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        repeat (8) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({in_ready, we, wdest, wdata, flags} !== {1'b1, 1'b0, 4'd0, 16'd0, 3'd0}) begin failures++; $display("FAIL midmul_reset: got rdy=%0b we=%0b d=%h data=%h f=%b want 1 0 0 0000 000", in_ready, we, wdest, wdata, flags); end
        @(negedge clk);
        rst_n = 1'b1;
        strobes = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (we === 1'b1) strobes++;
        end
        checks++; if (strobes != 0) begin failures++; $display("FAIL midmul_nowrite: got %0d strobes want 0", strobes); end
        drive(1'b1, 3'd0, 16'h0010, 16'h0020, 4'd9);
        tick();
        checks++; if ({in_ready, we, wdest, wdata, flags} !== {1'b1, 1'b1, 4'd9, 16'h0030, 3'b000}) begin failures++; $display("FAIL midmul_add: got rdy=%0b we=%0b d=%h data=%h f=%b want 1 1 9 0030 000", in_ready, we, wdest, wdata, flags); end
        drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        tick();
    endtask
`else
    task automatic test_illegal();
        drive(1'b1, 3'd1, 16'h0001, 16'h0002, 4'd5);
        tick();
        drive(1'b1, 3'd7, 16'($urandom), 16'($urandom), 4'd9);
        tick();
        checks++; if (ill !== 1'b1) begin failures++; $display("FAIL ill_pulse: got %0b want 1", ill); end
        checks++; if ({in_ready, we, wdest, wdata, flags} !== {1'b1, 1'b0, 4'd5, 16'hFFFF, 3'b110}) begin failures++; $display("FAIL ill_nowrite: got rdy=%0b we=%0b d=%h data=%h f=%b want 1 0 5 ffff 110", in_ready, we, wdest, wdata, flags); end
        drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        tick();
        checks++; if ({ill, we} !== 2'b00) begin failures++; $display("FAIL ill_end: got ill=%0b we=%0b want 0 0", ill, we); end
    endtask
`endif

    initial begin
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_random();
        test_async_reset();
`ifdef EXEC_MUL_EN
        test_mul();
`else
        test_illegal();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
